// File: rtl/pmod_meter_pkg.sv
// Shared types and constants for the PMOD frequency meter.
package pmod_meter_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StMeasure
    } meter_state_t;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILT_LEN    = 2;

endpackage

// File: rtl/pmod_freq_meter_if.sv
// Bundle of the PMOD input, run control and frequency readout signals.
interface pmod_freq_meter_if #(
    parameter int unsigned CNT_W = 27
);
    logic             pmod_pin;
    logic             enable;
    logic [CNT_W-1:0] freq_count;
    logic             count_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output pmod_pin,
        output enable,
        input  freq_count,
        input  count_valid,
        input  overflow,
        input  busy
    );

    modport slave (
        input  pmod_pin,
        input  enable,
        output freq_count,
        output count_valid,
        output overflow,
        output busy
    );
endinterface

// File: rtl/pmod_sync_edge.sv
// Synchronizes pmod_pin into sysclk and emits a 1-cycle pulse per rising edge.
// PMOD_METER_GLITCH_FILTER_EN adds a stability filter after the synchronizer.
module pmod_sync_edge
    import pmod_meter_pkg::*;
(
    input  logic sysclk,
    input  logic rst_n,
    input  logic pmod_pin,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   level;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pmod_pin};
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef PMOD_METER_GLITCH_FILTER_EN
    logic [FILT_LEN-2:0] hist_q, hist_d;
    logic                filt_q, filt_d;

    // Level moves only once FILT_LEN consecutive synchronized samples agree.
    always_comb begin
        hist_d = (FILT_LEN - 1)'({hist_q, sync_q[SYNC_STAGES-1]});
        filt_d = filt_q;
        if (&{hist_q, sync_q[SYNC_STAGES-1]}) begin
            filt_d = 1'b1;
        end else if (~|{hist_q, sync_q[SYNC_STAGES-1]}) begin
            filt_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        prev_d = level;
        rise   = level & ~prev_q;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/pmod_freq_meter.sv
// Counts rising edges of pmod_pin over back-to-back gate windows of GATE_CYCLES sysclk cycles.
// Optional input glitch filter: define PMOD_METER_GLITCH_FILTER_EN.
module pmod_freq_meter
    import pmod_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic              sysclk,
    input  logic              rst_n,
    pmod_freq_meter_if.slave  bus
);
    localparam int unsigned    GateW    = $clog2(GATE_CYCLES);
    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

    meter_state_t     state_q, state_d;
    logic [GateW-1:0] gate_q, gate_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic             rise;
    logic [CNT_W-1:0] edge_inc;
    logic             sat_inc;

    pmod_sync_edge u_sync_edge (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .pmod_pin (bus.pmod_pin),
        .rise     (rise)
    );

    // Edge count including this cycle's edge, saturating at all-ones.
    always_comb begin
        edge_inc = edge_q;
        sat_inc  = sat_q;
        if (rise) begin
            if (&edge_q) begin
                sat_inc = 1'b1;
            end else begin
                edge_inc = edge_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StMeasure;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end
            end
            StMeasure: begin
                if (gate_q == GateLast) begin
                    freq_d  = edge_inc;
                    ovf_d   = sat_inc;
                    valid_d = 1'b1;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                    state_d = bus.enable ? StMeasure : StIdle;
                end else if (!bus.enable) begin
                    state_d = StIdle;
                end else begin
                    gate_d = gate_q + GateW'(1);
                    edge_d = edge_inc;
                    sat_d  = sat_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bus.freq_count  = freq_q;
    assign bus.overflow    = ovf_q;
    assign bus.count_valid = valid_q;
    assign bus.busy        = (state_q == StMeasure);

endmodule

// File: tb/tb_pmod_freq_meter.sv
// Directed bench for pmod_freq_meter with GATE_CYCLES = 100 (CNT_W = 8 and CNT_W = 3 instances).
module tb_pmod_freq_meter;
    logic sysclk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   mode   = 0;       // 0: low, 1: high, 2: period 10, 3: 1-cycle pulse every 10
    int unsigned tick = 0;

    always #5 sysclk = ~sysclk;

    pmod_freq_meter_if #(.CNT_W(8)) if8 ();
    pmod_freq_meter_if #(.CNT_W(3)) if3 ();

    pmod_freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) u_dut8 (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (if8.slave)
    );

    pmod_freq_meter #(.GATE_CYCLES(100), .CNT_W(3)) u_dut3 (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (if3.slave)
    );

    // Pin pattern generator; if3 always sees a period-4 square wave.
    initial begin
        if8.pmod_pin = 1'b0;
        if3.pmod_pin = 1'b0;
        forever begin
            @(negedge sysclk);
            tick++;
            case (mode)
                0: if8.pmod_pin = 1'b0;
                1: if8.pmod_pin = 1'b1;
                2: if8.pmod_pin = (tick % 10) < 5;
                default: if8.pmod_pin = (tick % 10) == 0;
            endcase
            if3.pmod_pin = (tick % 4) < 2;
        end
    end

    // Returns negedges elapsed until count_valid, or budget+1 on timeout.
    task automatic wait_valid8(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge sysclk);
            n++;
            if (if8.count_valid) return;
        end
        n = budget + 1;
    endtask

    task automatic test_reset();
        @(negedge sysclk);
        checks++; if (if8.freq_count !== 8'd0) begin errors++; $display("FAIL reset_freq8: got %0d expected 0", if8.freq_count); end
        checks++; if (if8.count_valid !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %0b expected 0", if8.count_valid); end
        checks++; if (if8.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf8: got %0b expected 0", if8.overflow); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %0b expected 0", if8.busy); end
        checks++; if (if3.freq_count !== 3'd0) begin errors++; $display("FAIL reset_freq3: got %0d expected 0", if3.freq_count); end
        checks++; if (if3.busy !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %0b expected 0", if3.busy); end
    endtask

    task automatic test_period10();
        int n;
        if8.enable = 1'b0;
        mode = 2;
        repeat (20) @(negedge sysclk);
        if8.enable = 1'b1;
        @(negedge sysclk);
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL p10_busy: got %0b expected 1", if8.busy); end
        wait_valid8(250, n);
        checks++; if (n !== 100) begin errors++; $display("FAIL p10_first_latency: got %0d expected 100", n); end
        checks++; if (if8.freq_count !== 8'd10) begin errors++; $display("FAIL p10_freq0: got %0d expected 10", if8.freq_count); end
        checks++; if (if8.overflow !== 1'b0) begin errors++; $display("FAIL p10_ovf0: got %0b expected 0", if8.overflow); end
        for (int w = 1; w < 3; w++) begin
            wait_valid8(150, n);
            checks++; if (n !== 100) begin errors++; $display("FAIL p10_gap%0d: got %0d expected 100", w, n); end
            checks++; if (if8.freq_count !== 8'd10) begin errors++; $display("FAIL p10_freq%0d: got %0d expected 10", w, if8.freq_count); end
        end
        @(negedge sysclk);
        checks++; if (if8.count_valid !== 1'b0) begin errors++; $display("FAIL p10_pulse_width: got %0b expected 0", if8.count_valid); end
    endtask

    task automatic test_constant();
        int n;
        if8.enable = 1'b0;
        mode = 0;
        repeat (10) @(negedge sysclk);
        if8.enable = 1'b1;
        wait_valid8(250, n);
        checks++; if (n !== 101) begin errors++; $display("FAIL const0_latency: got %0d expected 101", n); end
        checks++; if (if8.freq_count !== 8'd0) begin errors++; $display("FAIL const0_freq: got %0d expected 0", if8.freq_count); end
        if8.enable = 1'b0;
        mode = 1;
        repeat (10) @(negedge sysclk);
        if8.enable = 1'b1;
        for (int w = 0; w < 2; w++) begin
            wait_valid8(250, n);
            checks++; if (n > 250) begin errors++; $display("FAIL const1_timeout%0d: got %0d expected <=250", w, n); end
            checks++; if (if8.freq_count !== 8'd0) begin errors++; $display("FAIL const1_freq%0d: got %0d expected 0", w, if8.freq_count); end
        end
    endtask

    task automatic test_overflow();
        int n;
        if3.enable = 1'b1;
        for (int w = 0; w < 2; w++) begin
            n = 0;
            while (n < 250) begin
                @(negedge sysclk);
                n++;
                if (if3.count_valid) break;
            end
            checks++; if (if3.count_valid !== 1'b1) begin errors++; $display("FAIL ovf_timeout%0d: got %0b expected 1", w, if3.count_valid); end
            checks++; if (if3.freq_count !== 3'd7) begin errors++; $display("FAIL ovf_freq%0d: got %0d expected 7", w, if3.freq_count); end
            checks++; if (if3.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag%0d: got %0b expected 1", w, if3.overflow); end
        end
    endtask

    task automatic test_abort();
        int n;
        bit seen;
        if8.enable = 1'b0;
        mode = 2;
        repeat (20) @(negedge sysclk);
        if8.enable = 1'b1;
        wait_valid8(250, n);
        checks++; if (if8.freq_count !== 8'd10) begin errors++; $display("FAIL abort_pre_freq: got %0d expected 10", if8.freq_count); end
        repeat (50) @(negedge sysclk);
        if8.enable = 1'b0;
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %0b expected 1", if8.busy); end
        @(negedge sysclk);
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %0b expected 0", if8.busy); end
        seen = 1'b0;
        repeat (150) begin
            @(negedge sysclk);
            if (if8.count_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_valid: got %0b expected 0", seen); end
        checks++; if (if8.freq_count !== 8'd10) begin errors++; $display("FAIL abort_freq_hold: got %0d expected 10", if8.freq_count); end
    endtask

    task automatic test_reset_mid();
        int n;
        if8.enable = 1'b1;
        wait_valid8(250, n);
        repeat (60) @(negedge sysclk);
        rst_n = 1'b0;
        #1;
        checks++; if (if8.freq_count !== 8'd0) begin errors++; $display("FAIL rmid_freq: got %0d expected 0", if8.freq_count); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", if8.busy); end
        checks++; if (if8.overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf: got %0b expected 0", if8.overflow); end
        checks++; if (if3.overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf3: got %0b expected 0", if3.overflow); end
        checks++; if (if3.freq_count !== 3'd0) begin errors++; $display("FAIL rmid_freq3: got %0d expected 0", if3.freq_count); end
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        wait_valid8(250, n);
        checks++; if (n !== 101) begin errors++; $display("FAIL rmid_first_valid: got %0d expected 101", n); end
    endtask

    task automatic test_glitch();
        int n;
        logic [7:0] exp_freq;
`ifdef PMOD_METER_GLITCH_FILTER_EN
        exp_freq = 8'd0;
`else
        exp_freq = 8'd10;
`endif
        if8.enable = 1'b0;
        mode = 3;
        repeat (20) @(negedge sysclk);
        if8.enable = 1'b1;
        wait_valid8(250, n);
        checks++; if (n !== 101) begin errors++; $display("FAIL glitch_latency: got %0d expected 101", n); end
        checks++; if (if8.freq_count !== exp_freq) begin errors++; $display("FAIL glitch_freq: got %0d expected %0d", if8.freq_count, exp_freq); end
    endtask

    initial begin
        rst_n = 1'b0;
        if8.enable = 1'b0;
        if3.enable = 1'b0;
        repeat (3) @(negedge sysclk);
        test_reset();
        rst_n = 1'b1;
        test_period10();
        test_constant();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmod_freq_meter.md
# pmod_freq_meter

Receive-side counterpart of the PMOD clock output: samples an external square wave arriving on a PMOD input pin, synchronizes it into the `sysclk` domain, and counts its rising edges over a fixed gate window of `sysclk` cycles. At the end of each window it publishes the edge count as a frequency reading. It sits between the PMOD connector and display or readout logic, and is used to check a PMOD clock loop-back or an external oscillator.

## Interface
- `GATE_CYCLES`, default 100_000_000 — gate window length in `sysclk` cycles (1 s at 100 MHz); minimum 4.
- `CNT_W`, default 27 — width of the edge counter and of `freq_count`.

- `sysclk` in 1 — system clock; all logic is on its rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `pmod_pin` in 1 — external signal; asynchronous to `sysclk`.
- `enable` in 1 — level; high runs back-to-back measurement windows.
- `freq_count` out CNT_W — edge count latched at the end of the last completed window.
- `count_valid` out 1 — one-cycle pulse when `freq_count` updates.
- `overflow` out 1 — latched with `freq_count`; 1 if the count saturated in that window.
- `busy` out 1 — high while a window is in progress.

## Operation
- Input path: 2-flop synchronizer, then a rising-edge detector (`sync_q & ~prev_q`). `prev_q` resets to 0.
- The FSM has two states: IDLE and MEASURE. Reset state is IDLE.
- IDLE → MEASURE when `enable` = 1. On entry, the gate counter and edge counter are both cleared.
- MEASURE: the gate counter increments every cycle. The edge counter increments on each detected edge and saturates at all-ones; a saturating increment sets a sticky `sat` bit.
- Window end (gate counter = GATE_CYCLES−1):
  - `freq_count` ← edge counter plus this cycle's edge, saturating.
  - `overflow` ← `sat`.
  - `count_valid` pulses.
  - If `enable` is still 1, the counters clear and the next window starts the following cycle, with no gap. Otherwise the FSM goes to IDLE.
- `enable` falling mid-window: the window is aborted and the FSM returns to IDLE. No `count_valid`; `freq_count` and `overflow` hold their old values.
- `busy` = (state == MEASURE).
- Reset values: `freq_count` 0, `count_valid` 0, `overflow` 0, `busy` 0; synchronizer flops 0.

## Timing
- A `pmod_pin` rising edge reaches the edge counter 3 `sysclk` cycles later: 2 synchronizer cycles plus 1 detect cycle.
- Edges still inside that pipeline at a window boundary are counted in the next window. An edge is never counted twice or dropped across back-to-back windows.
- `count_valid` and the new `freq_count`/`overflow` values appear in the cycle after the last gate cycle, and all three are registered.
- Measurable input: high and low each at least 1 `sysclk` period, so the maximum input is `sysclk`/2. Faster inputs alias; this is not flagged.
- Reset asserted mid-window: all state clears immediately; no `count_valid` is produced.

## Configuration
- `PMOD_METER_GLITCH_FILTER_EN` defined:
  - A stability filter follows the synchronizer. The filtered level changes only after 2 consecutive equal synchronized samples.
  - Pulses shorter than 2 cycles are rejected.
  - Edge latency becomes 5 cycles.
  - Minimum high/low time becomes 2 cycles, so the maximum input is `sysclk`/4.
- Undefined: no filter, 3-cycle latency, maximum input `sysclk`/2.

## Structure
- Package `pmod_meter_pkg`:
  - state enum `meter_state_t` (IDLE, MEASURE);
  - `SYNC_STAGES` = 2;
  - `FILT_LEN` = 2.
- Sub-module `pmod_sync_edge`: synchronizer, optional filter, and edge detector. Inputs `sysclk`, `rst_n`, `pmod_pin`; output `rise` (1-cycle pulse). It contains the only `PMOD_METER_GLITCH_FILTER_EN` logic.
- The top level holds the FSM, gate counter, edge counter and output registers.

## Test plan
All scenarios use `GATE_CYCLES` = 100 and `CNT_W` = 8 unless stated.
- `pmod_pin` toggles every 5 `sysclk` cycles (period 10), `enable` held high → `count_valid` every 100 cycles, `freq_count` = 10, `overflow` = 0; successive windows are all 10.
- `pmod_pin` held at 0, then held at 1 → `freq_count` = 0 each window.
- `CNT_W` = 3, period-4 input → 25 real edges; `freq_count` = 7, `overflow` = 1.
- `enable` dropped at cycle 50 of a window → no `count_valid`, `busy` falls the next cycle, `freq_count` keeps the previous value.
- `rst_n` pulsed low at cycle 60 → all outputs 0 immediately. After release with `enable` high, the first `count_valid` arrives 100 cycles after MEASURE entry.
- 1-cycle-wide high pulses every 10 cycles → `freq_count` = 10 without `PMOD_METER_GLITCH_FILTER_EN`, and 0 with it.
